fpu_unpack_norm: RTL and testbench
==================================

# fpu_unpack_norm

Parametrised, handshaked successor to the combinational unpack/pretest stage in the FPU front end. It accepts an operand pair and splits each operand into sign, exponent and fraction. It classifies each operand as zero, subnormal, infinity, quiet NaN or signalling NaN. It then iteratively normalises subnormal operands, so downstream add/mul datapaths always receive a mantissa with the hidden bit set and a signed, widened exponent.

## Interface
Parameters:
- EXP_W, 8, exponent field width. 5, 8 and 11 must be supported.
- FRAC_W, 23, fraction field width. 10, 23 and 52 must be supported.
- W, derived, 1+EXP_W+FRAC_W, operand width. Not overridable.

Ports:
- clk  in  1  sole clock. All state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept a pair.
- raw_a, raw_b  in  W  IEEE-754 operands.
- out_valid  out  1  unpacked result present.
- out_ready  in  1  consumer accepts the result.
- sign_a, sign_b  out  1  sign bits.
- exp_a, exp_b  out  EXP_W+2  signed (two's complement) biased exponent after normalisation.
- mant_a, mant_b  out  FRAC_W+1  mantissa including the hidden bit.
- cls_a, cls_b  out  5  class flags: {snan, qnan, inf, subn, zero}. One-hot, or all-zero for a normal operand.

## Operation
- FSM states: IDLE, NORM, DONE.
- in_ready = 1 only in IDLE with rst low. Only one pair is in flight at a time.
- IDLE, on in_valid: register the fields and compute the classes.
  - If any operand is subnormal, go to NORM. Otherwise go to DONE.
- Per-operand register load, at capture:
  - Normal: mant = {1, frac}; exp = zero-extended exponent field.
  - Zero: mant = 0; exp = 0.
  - Subnormal: mant = {0, frac}; exp = +1.
  - Inf/NaN: mant = {0, frac}; exp = 2^EXP_W − 1.
- NaN split: qnan when frac MSB = 1. snan when frac MSB = 0 and frac ≠ 0.
- NORM, each cycle: for each subnormal-classed operand whose mant MSB is 0, shift mant left by 1 and decrement exp by 1. Both operands shift in parallel.
  - When every subnormal operand has its MSB set, go to DONE.
- DONE: out_valid = 1.
  - On out_ready, go to IDLE.
  - Outputs hold stable while out_ready = 0.
- cls flags always reflect the original encoding; normalisation does not clear subn.
- exp never overflows: its minimum is 1 − FRAC_W, which fits in EXP_W+2 bits signed.

## Timing
- Reset values: state IDLE, out_valid 0, all data and flag outputs 0. in_ready is 0 while rst is high and 1 in the first cycle after release.
- Latency, no subnormal present: out_valid rises the cycle after the in_valid && in_ready edge.
- Latency, subnormal present: 1 + k cycles, where k = max leading-zero count over the subnormal fractions (1 ≤ k ≤ FRAC_W).
- Throughput: one pair per (latency + 1) cycles when out_ready is held at 1.
- The DONE→IDLE edge happens on out_ready. in_ready reasserts in the following cycle; there is no same-cycle accept-and-release.
- rst in any state, including NORM or DONE: the in-flight pair is discarded, out_valid drops at the next edge, and the pair is never emitted.
- in_valid asserted outside IDLE is ignored, and the operands are not captured.

## Configuration
- FPU_DAZ_EN defined: denormals-are-zero mode.
  - Subnormal inputs are classified as zero (cls = zero, subn never set).
  - Their mant and exp are 0 and the sign is preserved.
  - The NORM state is not compiled in, so latency is always 1.
- FPU_DAZ_EN undefined: full subnormal normalisation as above.

## Test plan
All values use EXP_W = 8, FRAC_W = 23.
- Normal pair: raw_a = 0x3F800000, raw_b = 0xC0000000. Expect out_valid 1 cycle after accept, mant_a = 0x800000, exp_a = 127, cls_a = 0, sign_b = 1, exp_b = 128.
- Min subnormal: raw_a = 0x00000001, raw_b = 0x3F800000. Expect out_valid 24 cycles after accept, mant_a = 0x800000, exp_a = −22, cls_a = 5'b00010, b unchanged.
- Specials: raw_a = 0x7F800000, raw_b = 0x7FC00000 gives cls_a = 5'b00100, cls_b = 5'b01000. Then raw_a = 0x7F800001, raw_b = 0x80000000 gives cls_a = 5'b10000, cls_b = 5'b00001, sign_b = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE. Outputs stay stable and in_ready = 0. Release: in_ready returns 1 in the next cycle and the next pair is accepted correctly.
- Reset mid-NORM: raw_a = 0x00000001, assert rst on the 5th NORM cycle. out_valid never rises for that pair. After release, pair 0x00400000/0 yields exp_a = 0, mant_a = 0x800000, latency 2.
- With FPU_DAZ_EN: raw_a = 0x80400000 gives cls_a = 5'b00001, sign_a = 1, mant_a = 0, exp_a = 0, latency 1.

Source files
------------

// File: rtl/fpu_unpack_norm_if.sv
// Handshake and operand/result bundle for fpu_unpack_norm.
// master drives operands and out_ready; slave is the unpack/normalise stage.
interface fpu_unpack_norm_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
   localparam int W = 1 + EXP_W + FRAC_W;

   logic                    in_valid;
   logic                    in_ready;
   logic [W-1:0]            raw_a;
   logic [W-1:0]            raw_b;
   logic                    out_valid;
   logic                    out_ready;
   logic                    sign_a;
   logic                    sign_b;
   logic signed [EXP_W+1:0] exp_a;
   logic signed [EXP_W+1:0] exp_b;
   logic [FRAC_W:0]         mant_a;
   logic [FRAC_W:0]         mant_b;
   logic [4:0]              cls_a;
   logic [4:0]              cls_b;

   modport master (
      output in_valid, raw_a, raw_b, out_ready,
      input  in_ready, out_valid, sign_a, sign_b, exp_a, exp_b,
             mant_a, mant_b, cls_a, cls_b
   );

   modport slave (
      input  in_valid, raw_a, raw_b, out_ready,
      output in_ready, out_valid, sign_a, sign_b, exp_a, exp_b,
             mant_a, mant_b, cls_a, cls_b
   );
endinterface

// File: rtl/fpu_unpack_norm.sv
// FPU front end: unpack and classify an operand pair, then normalise subnormals one bit per cycle.
// Define FPU_DAZ_EN to treat subnormal inputs as signed zero and drop the NORM state.
module fpu_unpack_norm #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
   input logic clk,
   input logic rst,
   fpu_unpack_norm_if.slave bus
);
   localparam int W  = 1 + EXP_W + FRAC_W;
   localparam int XW = EXP_W + 2;

   // Bit positions inside the {snan, qnan, inf, subn, zero} class vector.
   localparam int C_ZERO = 0;
   localparam int C_SUBN = 1;
   localparam int C_INF  = 2;
   localparam int C_QNAN = 3;
   localparam int C_SNAN = 4;

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   typedef struct packed {
      logic            sign;
      logic [XW-1:0]   exp;
      logic [FRAC_W:0] mant;
      logic [4:0]      cls;
   } opnd_t;

   function automatic opnd_t unpack(input logic [W-1:0] raw);
      logic [EXP_W-1:0]  e;
      logic [FRAC_W-1:0] f;
      logic              f_zero;
      opnd_t             o;
      e      = raw[W-2:FRAC_W];
      f      = raw[FRAC_W-1:0];
      f_zero = (f == '0);
      o.sign = raw[W-1];
      o.cls  = '0;
      o.exp  = {2'b00, e};
      o.mant = {1'b1, f};
      if (e == '0) begin
         o.exp  = '0;
         o.mant = '0;
`ifdef FPU_DAZ_EN
         o.cls[C_ZERO] = 1'b1;
`else
         if (f_zero) begin
            o.cls[C_ZERO] = 1'b1;
         end else begin
            o.cls[C_SUBN] = 1'b1;
            o.exp         = XW'(1);
            o.mant        = {1'b0, f};
         end
`endif
      end else if (e == '1) begin
         o.mant = {1'b0, f};
         if (f_zero)             o.cls[C_INF]  = 1'b1;
         else if (f[FRAC_W-1])   o.cls[C_QNAN] = 1'b1;
         else                    o.cls[C_SNAN] = 1'b1;
      end
      return o;
   endfunction

   state_t state;
   opnd_t  a_q, b_q;
   opnd_t  a_in, b_in;
   logic   out_valid_q;

   assign a_in = unpack(bus.raw_a);
   assign b_in = unpack(bus.raw_b);

`ifndef FPU_DAZ_EN
   // An operand is finished once its MSB is set, or will be after this cycle's shift.
   logic a_step, b_step, a_done, b_done;
   assign a_step = a_q.cls[C_SUBN] && !a_q.mant[FRAC_W];
   assign b_step = b_q.cls[C_SUBN] && !b_q.mant[FRAC_W];
   assign a_done = !a_step || a_q.mant[FRAC_W-1];
   assign b_done = !b_step || b_q.mant[FRAC_W-1];
`endif

   // NOTE: in_ready is combinational on rst so it is low for the whole reset window.
   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.sign_a    = a_q.sign;
   assign bus.sign_b    = b_q.sign;
   assign bus.exp_a     = a_q.exp;
   assign bus.exp_b     = b_q.exp;
   assign bus.mant_a    = a_q.mant;
   assign bus.mant_b    = b_q.mant;
   assign bus.cls_a     = a_q.cls;
   assign bus.cls_b     = b_q.cls;

   // NOTE: non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q <= a_in;
                  b_q <= b_in;
`ifdef FPU_DAZ_EN
                  state       <= DONE;
                  out_valid_q <= 1'b1;
`else
                  if (a_in.cls[C_SUBN] || b_in.cls[C_SUBN]) begin
                     state <= NORM;
                  end else begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                  end
`endif
               end
            end
`ifndef FPU_DAZ_EN
            NORM: begin
               if (a_step) begin
                  a_q.mant <= a_q.mant << 1;
                  a_q.exp  <= a_q.exp - XW'(1);
               end
               if (b_step) begin
                  b_q.mant <= b_q.mant << 1;
                  b_q.exp  <= b_q.exp - XW'(1);
               end
               if (a_done && b_done) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
`endif
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fpu_unpack_norm.sv
// Scoreboard bench for fpu_unpack_norm (binary32): directed classes, backpressure, reset mid-flight, random pairs.
`timescale 1ns/1ps
module tb_fpu_unpack_norm;
   localparam int EW = 8;
   localparam int FW = 23;
   localparam int XW = EW + 2;

   typedef struct {
      logic          sign;
      logic [XW-1:0] exp;
      logic [FW:0]   mant;
      logic [4:0]    cls;
      int            lat;
   } exp_t;

   typedef struct {
      exp_t a;
      exp_t b;
   } pair_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   pair_t sb[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   logic          obs_sign_a, obs_sign_b;
   logic [XW-1:0] obs_exp_a, obs_exp_b;
   logic [FW:0]   obs_mant_a, obs_mant_b;
   logic [4:0]    obs_cls_a, obs_cls_b;

   fpu_unpack_norm_if #(.EXP_W(EW), .FRAC_W(FW)) bus ();

   fpu_unpack_norm #(.EXP_W(EW), .FRAC_W(FW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Reference: locate the leading one directly rather than shifting step by step.
   function automatic exp_t model(input logic [31:0] raw);
      exp_t        r;
      logic [7:0]  e;
      logic [22:0] f;
      int          top;
      int          sh;
      e      = raw[30:23];
      f      = raw[22:0];
      r.sign = raw[31];
      r.lat  = 1;
      r.cls  = 5'b00000;
      r.exp  = {2'b00, e};
      r.mant = {1'b1, f};
      if (e == 8'h00) begin
         r.exp  = '0;
         r.mant = '0;
         r.cls  = 5'b00001;
`ifndef FPU_DAZ_EN
         if (f != 0) begin
            top = 0;
            for (int i = 0; i < FW; i++) if (f[i]) top = i;
            sh     = FW - top;
            r.mant = {1'b0, f} << sh;
            r.exp  = XW'(1 - sh);
            r.cls  = 5'b00010;
            r.lat  = 1 + sh;
         end
`endif
      end else if (e == 8'hFF) begin
         r.mant = {1'b0, f};
         if (f == 0)      r.cls = 5'b00100;
         else if (f[22])  r.cls = 5'b01000;
         else             r.cls = 5'b10000;
      end
      return r;
   endfunction

   function automatic logic [79:0] snap();
      return {bus.sign_a, bus.sign_b, bus.exp_a, bus.exp_b,
              bus.mant_a, bus.mant_b, bus.cls_a, bus.cls_b};
   endfunction

   task automatic do_pair(input logic [31:0] a, input logic [31:0] b, input int hold);
      pair_t       p;
      int          cyc;
      int          lat;
      logic [79:0] s;
      @(negedge clk);
      bus.raw_a    = a;
      bus.raw_b    = b;
      bus.in_valid = 1'b1;
      cyc = 0;
      while (!bus.in_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("accept_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      p.a = model(a);
      p.b = model(b);
      sb.push_back(p);
      @(negedge clk);
      // Garbage offered while busy must be ignored.
      bus.raw_a = $urandom;
      bus.raw_b = $urandom;
      cyc = 1;
      while (!bus.out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("out_valid", bus.out_valid, 1'b1);
      lat = (p.a.lat > p.b.lat) ? p.a.lat : p.b.lat;
      check("latency", cyc, lat);
      if (hold > 0) begin
         s = snap();
         bus.out_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_stable", snap(), s);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      if (sb.size() == 0) begin
         check("sb_nonempty", 1'b0, 1'b1);
      end else begin
         p = sb.pop_front();
         check("sign_a", bus.sign_a, p.a.sign);
         check("sign_b", bus.sign_b, p.b.sign);
         check("exp_a", $unsigned(bus.exp_a), p.a.exp);
         check("exp_b", $unsigned(bus.exp_b), p.b.exp);
         check("mant_a", bus.mant_a, p.a.mant);
         check("mant_b", bus.mant_b, p.b.mant);
         check("cls_a", bus.cls_a, p.a.cls);
         check("cls_b", bus.cls_b, p.b.cls);
      end
      obs_sign_a = bus.sign_a;
      obs_sign_b = bus.sign_b;
      obs_exp_a  = $unsigned(bus.exp_a);
      obs_exp_b  = $unsigned(bus.exp_b);
      obs_mant_a = bus.mant_a;
      obs_mant_b = bus.mant_b;
      obs_cls_a  = bus.cls_a;
      obs_cls_b  = bus.cls_b;
      @(posedge clk);
      @(negedge clk);
      check("drop_valid", bus.out_valid, 1'b0);
      check("release_ready", bus.in_ready, 1'b1);
   endtask

   function automatic logic [31:0] rnd_op();
      int          sel;
      logic [7:0]  e;
      logic [22:0] f;
      sel = $urandom_range(0, 3);
      f   = 23'($urandom) >> $urandom_range(0, 22);
      if (sel == 0)      e = 8'h00;
      else if (sel == 1) e = 8'hFF;
      else               e = 8'($urandom_range(1, 254));
      return {1'($urandom), e, f};
   endfunction

   initial begin
      int seen;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.raw_a     = '0;
      bus.raw_b     = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_mant_a", bus.mant_a, '0);
      check("rst_exp_b", $unsigned(bus.exp_b), '0);
      check("rst_cls_a", bus.cls_a, '0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", bus.in_ready, 1'b1);

      // Normal pair
      do_pair(32'h3F800000, 32'hC0000000, 0);
      check("np_mant_a", obs_mant_a, 24'h800000);
      check("np_exp_a", obs_exp_a, 10'd127);
      check("np_cls_a", obs_cls_a, 5'b00000);
      check("np_sign_b", obs_sign_b, 1'b1);
      check("np_exp_b", obs_exp_b, 10'd128);

      // Minimum subnormal
      do_pair(32'h00000001, 32'h3F800000, 0);
`ifndef FPU_DAZ_EN
      check("ms_mant_a", obs_mant_a, 24'h800000);
      check("ms_exp_a", obs_exp_a, 10'h3EA);
      check("ms_cls_a", obs_cls_a, 5'b00010);
`endif
      check("ms_exp_b", obs_exp_b, 10'd127);

      // Specials
      do_pair(32'h7F800000, 32'h7FC00000, 0);
      check("sp_cls_a_inf", obs_cls_a, 5'b00100);
      check("sp_cls_b_qnan", obs_cls_b, 5'b01000);
      do_pair(32'h7F800001, 32'h80000000, 0);
      check("sp_cls_a_snan", obs_cls_a, 5'b10000);
      check("sp_cls_b_zero", obs_cls_b, 5'b00001);
      check("sp_sign_b", obs_sign_b, 1'b1);

      // Backpressure, then the next pair must go through cleanly
      do_pair(32'h00000010, 32'h40490FDB, 5);
      do_pair(32'h3F000000, 32'h00400000, 0);

      // Reset during normalisation
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.raw_a    = 32'h00000001;
      bus.raw_b    = 32'h00000000;
      bus.in_valid = 1'b1;
      check("mr_accept_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mr_valid_dropped", bus.out_valid, 1'b0);
      check("mr_in_ready_low", bus.in_ready, 1'b0);
      check("mr_mant_cleared", bus.mant_a, '0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("mr_ready_back", bus.in_ready, 1'b1);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      check("mr_never_emitted", seen, 0);
      do_pair(32'h00400000, 32'h00000000, 0);
`ifndef FPU_DAZ_EN
      check("mr_exp_a", obs_exp_a, 10'd0);
      check("mr_mant_a", obs_mant_a, 24'h800000);
`endif

      // Denormals-are-zero directed case (model covers either build)
      do_pair(32'h80400000, 32'h3F800000, 0);
`ifdef FPU_DAZ_EN
      check("daz_cls_a", obs_cls_a, 5'b00001);
      check("daz_sign_a", obs_sign_a, 1'b1);
      check("daz_mant_a", obs_mant_a, '0);
      check("daz_exp_a", obs_exp_a, '0);
`endif

      // Random mix of classes with occasional backpressure
      for (int i = 0; i < 24; i++) begin
         do_pair(rnd_op(), rnd_op(), $urandom_range(0, 2));
      end

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
